// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - two-requester arbiter/sequencer for a single-port register file
// Optional feature macro: REGFILE_ARB_FIXED_PRIO_EN (defined: A has fixed priority; undefined: round-robin).
module regfile_port_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int MEM_DEPTH  = 8,
  parameter int MEM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [MEM_WIDTH-1:0]  a_wdata,
  output logic                  a_gnt,
  output logic                  a_ack,
  output logic [MEM_WIDTH-1:0]  a_rdata,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [MEM_WIDTH-1:0]  b_wdata,
  output logic                  b_gnt,
  output logic                  b_ack,
  output logic [MEM_WIDTH-1:0]  b_rdata,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [MEM_WIDTH-1:0]  rf_wr_data,
  input  logic [MEM_WIDTH-1:0]  rf_rd_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_b_q, last_b_d;       // 1: most recent grant went to B
  logic                  cmd_b_q, cmd_b_d;         // 1: current transaction belongs to B
  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [MEM_WIDTH-1:0]  cmd_wdata_q, cmd_wdata_d;
  logic                  a_gnt_q, a_gnt_d;
  logic                  b_gnt_q, b_gnt_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic                  ack_rd_q, ack_rd_d;       // the ack being issued completes a read
  logic [MEM_WIDTH-1:0]  a_rdata_q, a_rdata_d;
  logic [MEM_WIDTH-1:0]  b_rdata_q, b_rdata_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [MEM_WIDTH-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic                  pick_b;

  // Winner selection when at least one requester is asking in IDLE.
  always_comb begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    pick_b = b_req & ~a_req;
`else
    pick_b = b_req & (~a_req | ~last_b_q);
`endif
  end

  // Next-state and registered-output computation for the IDLE -> ISSUE -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    cmd_b_d      = cmd_b_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    ack_rd_d     = 1'b0;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    // Read data lands on rf_rd_data during the ack cycle; capture it there so it holds afterwards.
    a_rdata_d    = a_rdata;
    b_rdata_d    = b_rdata;
    case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          cmd_b_d     = pick_b;
          cmd_wr_d    = pick_b ? b_wr    : a_wr;
          cmd_addr_d  = pick_b ? b_addr  : a_addr;
          cmd_wdata_d = pick_b ? b_wdata : a_wdata;
          a_gnt_d     = ~pick_b;
          b_gnt_d     = pick_b;
          last_b_d    = pick_b;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rf_wr_en_d   = cmd_wr_q;
        rf_rd_en_d   = ~cmd_wr_q;
        rf_addr_d    = cmd_addr_q;
        rf_wr_data_d = cmd_wdata_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        a_ack_d  = ~cmd_b_q;
        b_ack_d  = cmd_b_q;
        ack_rd_d = ~cmd_wr_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_b_q     <= 1'b1;
      cmd_b_q      <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      ack_rd_q     <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      last_b_q     <= last_b_d;
      cmd_b_q      <= cmd_b_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      ack_rd_q     <= ack_rd_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign a_gnt      = a_gnt_q;
  assign b_gnt      = b_gnt_q;
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_rdata    = (a_ack_q && ack_rd_q) ? rf_rd_data : a_rdata_q;
  assign b_rdata    = (b_ack_q && ack_rd_q) ? rf_rd_data : b_rdata_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - self-checking bench for regfile_port_arbiter
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_wr = 1'b0;
  logic [2:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        b_req = 1'b0, b_wr = 1'b0;
  logic [2:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        a_gnt, a_ack, b_gnt, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic        rf_wr_en, rf_rd_en, busy;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wr_data;
  logic [15:0] rf_rd_data = '0;

  int checks = 0;
  int errors = 0;

  regfile_port_arbiter #(.ADDR_WIDTH(3), .MEM_DEPTH(8), .MEM_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file: registered RdData, both strobes = no-op, contents survive arbiter reset.
  logic [15:0] rf_mem [8];
  initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
  always @(posedge clk) begin
    if (rf_wr_en && !rf_rd_en) rf_mem[rf_addr] <= rf_wr_data;
    if (rf_rd_en && !rf_wr_en) rf_rd_data <= rf_mem[rf_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-timeline model: a grant decided at edge g shows gnt in cycle g,
  // the strobe in cycle g+1, the ack in cycle g+2; next arbitration at edge g+3.
  int          cyc = 0;
  bit          model_en = 0;
  bit          last_b_m, pend, p_b, p_wr, p_strobed, win_b;
  int          g, next_arb;
  logic [2:0]  p_addr;
  logic [15:0] p_wdata, rval;
  logic [15:0] mmem [8];
  logic        e_agnt, e_bgnt, e_aack, e_back, e_wr, e_rd, e_busy;
  logic [2:0]  e_addr;
  logic [15:0] e_wdata, e_ard, e_brd;
  initial for (int i = 0; i < 8; i++) mmem[i] = '0;

  always @(posedge clk) begin
    cyc++;
    e_agnt = 0; e_bgnt = 0; e_aack = 0; e_back = 0; e_wr = 0; e_rd = 0;
    if (pend && p_strobed && cyc == g + 2) begin
      if (p_wr) mmem[p_addr] = p_wdata;
      else rval = mmem[p_addr];
    end
    if (!rst) begin
      model_en = 1; pend = 0; last_b_m = 1; next_arb = cyc + 1;
      e_addr = '0; e_wdata = '0; e_ard = '0; e_brd = '0; e_busy = 0;
    end else if (model_en) begin
      if (pend && cyc == g + 1) begin
        e_wr = p_wr; e_rd = !p_wr; e_addr = p_addr; e_wdata = p_wdata; p_strobed = 1;
      end
      if (pend && cyc == g + 2) begin
        if (p_b) e_back = 1; else e_aack = 1;
        if (!p_wr) begin
          if (p_b) e_brd = rval; else e_ard = rval;
        end
        pend = 0;
      end
      if (!pend && cyc >= next_arb && (a_req || b_req)) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        win_b = !a_req;
`else
        win_b = (a_req && b_req) ? !last_b_m : b_req;
`endif
        p_b = win_b; p_wr = win_b ? b_wr : a_wr;
        p_addr = win_b ? b_addr : a_addr; p_wdata = win_b ? b_wdata : a_wdata;
        pend = 1; p_strobed = 0; g = cyc; next_arb = cyc + 3; last_b_m = win_b;
        if (win_b) e_bgnt = 1; else e_agnt = 1;
      end
      e_busy = pend;
    end
  end

  bit gnt_log [$];

  // Per-cycle comparison against the model, plus exclusivity properties.
  always @(negedge clk) begin
    if (model_en) begin
      chk("a_gnt", a_gnt, e_agnt);
      chk("b_gnt", b_gnt, e_bgnt);
      chk("a_ack", a_ack, e_aack);
      chk("b_ack", b_ack, e_back);
      chk("rf_wr_en", rf_wr_en, e_wr);
      chk("rf_rd_en", rf_rd_en, e_rd);
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_wr_data", rf_wr_data, e_wdata);
      chk("a_rdata", a_rdata, e_ard);
      chk("b_rdata", b_rdata, e_brd);
      chk("busy", busy, e_busy);
      chk("strobe_excl", rf_wr_en & rf_rd_en, 0);
      chk("gnt_excl", a_gnt & b_gnt, 0);
      chk("ack_excl", a_ack & b_ack, 0);
      if (a_gnt) gnt_log.push_back(1'b0);
      if (b_gnt) gnt_log.push_back(1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_a_gnt", a_gnt, 0);
    rst = 1'b1;
    step();

    // A write addr 3 = BEEF
    a_req = 1; a_wr = 1; a_addr = 3; a_wdata = 16'hBEEF;
    step(); chk("t1_a_gnt", a_gnt, 1); chk("t1_busy", busy, 1); a_req = 0;
    step(); chk("t1_wr_en", rf_wr_en, 1); chk("t1_addr", rf_addr, 3); chk("t1_wdata", rf_wr_data, 16'hBEEF);
    step(); chk("t1_a_ack", a_ack, 1); chk("t1_wr_en_off", rf_wr_en, 0);

    // B read addr 3, address changed right after gnt
    b_req = 1; b_wr = 0; b_addr = 3;
    step(); chk("t2_b_gnt", b_gnt, 1); b_req = 0; b_addr = 5;
    step(); chk("t2_rd_en", rf_rd_en, 1); chk("t2_addr", rf_addr, 3);
    step(); chk("t2_b_ack", b_ack, 1); chk("t2_b_rdata", b_rdata, 16'hBEEF);

    // Contention for 12 cycles
    gnt_log.delete();
    a_req = 1; a_wr = 0; a_addr = 1;
    b_req = 1; b_wr = 1; b_addr = 2; b_wdata = 16'h5555;
    repeat (12) step();
    a_req = 0; b_req = 0;
    repeat (3) step();
    chk("t3_gnt_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      chk("t3_g0", gnt_log[0], 0); chk("t3_g1", gnt_log[1], 0);
      chk("t3_g2", gnt_log[2], 0); chk("t3_g3", gnt_log[3], 0);
`else
      chk("t3_g0", gnt_log[0], 0); chk("t3_g1", gnt_log[1], 1);
      chk("t3_g2", gnt_log[2], 0); chk("t3_g3", gnt_log[3], 1);
`endif
    end

    // A write addr 7, reset while the write strobe is out
    a_req = 1; a_wr = 1; a_addr = 7; a_wdata = 16'h1234;
    step(); chk("t4_a_gnt", a_gnt, 1); a_req = 0;
    step(); chk("t4_wr_en", rf_wr_en, 1); rst = 0;
    step();
    chk("t4_busy", busy, 0); chk("t4_a_ack", a_ack, 0); chk("t4_wr_en0", rf_wr_en, 0);
    chk("t4_addr0", rf_addr, 0); chk("t4_wdata0", rf_wr_data, 0);
    rst = 1;
    step(); chk("t4_no_ack", a_ack, 0);
    a_req = 1; a_wr = 0; a_addr = 7;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        step();
        if (a_gnt) a_req = 0;
        if (a_ack) got = 1;
      end
      chk("t4_ack_seen", got, 1);
      chk("t4_rdata", a_rdata, 16'h1234);
    end

    // B requests during A's RESP
    a_req = 1; a_wr = 1; a_addr = 4; a_wdata = 16'h0A0A;
    step(); chk("t5_a_gnt", a_gnt, 1); a_req = 0;
    step(); b_req = 1; b_wr = 0; b_addr = 4;
    step(); chk("t5_a_ack", a_ack, 1); chk("t5_no_b_gnt", b_gnt, 0);
    step(); chk("t5_b_gnt", b_gnt, 1); b_req = 0; b_addr = 6;
    step(); chk("t5_rd_en", rf_rd_en, 1); chk("t5_addr", rf_addr, 4);
    step(); chk("t5_b_ack", b_ack, 1); chk("t5_b_rdata", b_rdata, 16'h0A0A);
    step(); chk("t5_b_hold", b_rdata, 16'h0A0A);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
